// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: valid/ready transport of one RGB duty triple
interface rgb_pwm_driver_if;
    logic duty_valid;
    logic duty_ready;
    logic [7:0] duty_r;
    logic [7:0] duty_g;
    logic [7:0] duty_b;
    modport master(output duty_valid, duty_r, duty_g, duty_b, input duty_ready);
    modport slave(input duty_valid, duty_r, duty_g, duty_b, output duty_ready);
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: edge-aligned RGB PWM with double-buffered duties applied at period boundaries
module rgb_pwm_driver #(
    parameter int PRESCALE   = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    rgb_pwm_driver_if.slave        duty,
    output logic                   redled,
    output logic                   greenled,
    output logic                   blueled,
    output logic                   frame_start
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    logic [0:0] state;
    logic [15:0] pre;
    logic [7:0] phase, phase_n;
    logic [7:0] pend_r, pend_g, pend_b;
    logic [7:0] act_r, act_g, act_b, act_r_n, act_g_n, act_b_n;
    logic tick, boundary, apply;
    assign tick = pre == 16'(PRESCALE - 1);
    assign boundary = tick && phase == 8'd254;
    assign apply = boundary && state == FULL;
    assign duty.duty_ready = state == EMPTY;
    // Pins are registered from next-state phase/duty so a new period shows up alongside frame_start.
    always_comb begin
        phase_n = tick ? (phase == 8'd254 ? 8'd0 : phase + 8'd1) : phase;
        act_r_n = apply ? pend_r : act_r;
        act_g_n = apply ? pend_g : act_g;
        act_b_n = apply ? pend_b : act_b;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            pre         <= 16'd0;
            phase       <= 8'd0;
            pend_r      <= 8'd0;
            pend_g      <= 8'd0;
            pend_b      <= 8'd0;
            act_r       <= 8'd0;
            act_g       <= 8'd0;
            act_b       <= 8'd0;
            frame_start <= 1'b0;
            redled      <= ACTIVE_LOW;
            greenled    <= ACTIVE_LOW;
            blueled     <= ACTIVE_LOW;
        end else begin
            pre         <= tick ? 16'd0 : pre + 16'd1;
            phase       <= phase_n;
            act_r       <= act_r_n;
            act_g       <= act_g_n;
            act_b       <= act_b_n;
            frame_start <= boundary;
            if (state == EMPTY && duty.duty_valid) begin
                pend_r <= duty.duty_r;
                pend_g <= duty.duty_g;
                pend_b <= duty.duty_b;
                state  <= FULL;
            end else if (apply) begin
                state <= EMPTY;
            end
            redled   <= (phase_n < act_r_n) ^ ACTIVE_LOW;
            greenled <= (phase_n < act_g_n) ^ ACTIVE_LOW;
            blueled  <= (phase_n < act_b_n) ^ ACTIVE_LOW;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed scoreboard bench over four PRESCALE/ACTIVE_LOW configurations
module tb_rgb_pwm_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic v = 1'b0;
    logic [7:0] dr = 8'd0, dg = 8'd0, db = 8'd0;
    logic [3:0] rl, gl, bl, fs, rdy;
    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int n;
    always #5 clk = ~clk;
    rgb_pwm_driver_if i0 (), i1 (), i2 (), i3 ();
    assign {i0.duty_valid, i0.duty_r, i0.duty_g, i0.duty_b} = {v, dr, dg, db};
    assign {i1.duty_valid, i1.duty_r, i1.duty_g, i1.duty_b} = {v, dr, dg, db};
    assign {i2.duty_valid, i2.duty_r, i2.duty_g, i2.duty_b} = {v, dr, dg, db};
    assign {i3.duty_valid, i3.duty_r, i3.duty_g, i3.duty_b} = {v, dr, dg, db};
    assign rdy = {i3.duty_ready, i2.duty_ready, i1.duty_ready, i0.duty_ready};
    rgb_pwm_driver #(.PRESCALE(16), .ACTIVE_LOW(1'b0)) d0 (.clk(clk), .reset(reset), .duty(i0),
        .redled(rl[0]), .greenled(gl[0]), .blueled(bl[0]), .frame_start(fs[0]));
    rgb_pwm_driver #(.PRESCALE(1), .ACTIVE_LOW(1'b0)) d1 (.clk(clk), .reset(reset), .duty(i1),
        .redled(rl[1]), .greenled(gl[1]), .blueled(bl[1]), .frame_start(fs[1]));
    rgb_pwm_driver #(.PRESCALE(2), .ACTIVE_LOW(1'b0)) d2 (.clk(clk), .reset(reset), .duty(i2),
        .redled(rl[2]), .greenled(gl[2]), .blueled(bl[2]), .frame_start(fs[2]));
    rgb_pwm_driver #(.PRESCALE(1), .ACTIVE_LOW(1'b1)) d3 (.clk(clk), .reset(reset), .duty(i3),
        .redled(rl[3]), .greenled(gl[3]), .blueled(bl[3]), .frame_start(fs[3]));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pins(input int d);
        return int'({rl[d], gl[d], bl[d]});
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        v = 1'b0;
        exp_q.delete();
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic send(input string tag, input int d, input int r, input int g, input int b, input int p);
        int k = 0;
        {dr, dg, db} = {8'(r), 8'(g), 8'(b)};
        v = 1'b1;
        while (!rdy[d] && k < 2000) begin
            cyc();
            k++;
        end
        if (k >= 2000) chk({tag, "_ready_timeout"}, k, 0);
        cyc();
        v = 1'b0;
        exp_q.push_back(r * p);
        exp_q.push_back(g * p);
        exp_q.push_back(b * p);
    endtask

    task automatic wait_fs(input string tag, input int d, input int lim, output int cnt);
        cnt = 0;
        while (!fs[d] && cnt < lim) begin
            cyc();
            cnt++;
        end
        if (cnt >= lim) chk({tag, "_fs_timeout"}, cnt, 0);
    endtask

    task automatic measure(input string tag, input int d, input int len, input logic al);
        int cr = 0, cg = 0, cb = 0, cf = 0, run = 0;
        logic lead = 1'b1;
        logic f0;
        f0 = fs[d];
        for (int i = 0; i < len; i++) begin
            cr += int'(rl[d] ^ al);
            cg += int'(gl[d] ^ al);
            cb += int'(bl[d] ^ al);
            cf += int'(fs[d]);
            lead = lead & (rl[d] ^ al);
            run += int'(lead);
            cyc();
        end
        chk({tag, "_fs_first"}, int'(f0), 1);
        chk({tag, "_fs_count"}, cf, 1);
        if (exp_q.size() < 3) begin
            chk({tag, "_scoreboard_depth"}, exp_q.size(), 3);
        end else begin
            int er, eg, eb;
            er = exp_q.pop_front();
            eg = exp_q.pop_front();
            eb = exp_q.pop_front();
            chk({tag, "_red_on"}, cr, er);
            chk({tag, "_red_leading"}, run, er);
            chk({tag, "_green_on"}, cg, eg);
            chk({tag, "_blue_on"}, cb, eb);
        end
    endtask

    initial begin
        // reset state and first frame_start, PRESCALE=16
        reset = 1'b1;
        cyc();
        chk("rst_in_pins", pins(0), 0);
        chk("rst_in_fs", int'(fs[0]), 0);
        chk("rst_in_ready", int'(rdy[0]), 1);
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_c0_pins", pins(0), 0);
        chk("rst_c0_fs", int'(fs[0]), 0);
        chk("rst_c0_ready", int'(rdy[0]), 1);
        wait_fs("rst", 0, 5000, n);
        chk("rst_first_fs_cycle", n, 255 * 16);

        // duty accuracy, PRESCALE=1
        do_reset();
        send("acc", 1, 128, 0, 255, 1);
        wait_fs("acc", 1, 600, n);
        chk("acc_fs_cycle", n + 1, 255);
        measure("acc", 1, 255, 1'b0);

        // back-to-back updates, PRESCALE=2, B held valid
        do_reset();
        {dr, dg, db} = {8'd10, 8'd10, 8'd10};
        v = 1'b1;
        chk("b2b_ready_c0", int'(rdy[2]), 1);
        exp_q.push_back(20); exp_q.push_back(20); exp_q.push_back(20);
        cyc();
        {dr, dg, db} = {8'd200, 8'd200, 8'd200};
        exp_q.push_back(400); exp_q.push_back(400); exp_q.push_back(400);
        n = 0;
        while (!rdy[2] && n < 2000) begin
            cyc();
            n++;
        end
        chk("b2b_ready_low_cycles", n, 509);
        chk("b2b_accept_on_fs", int'(fs[2]), 1);
        measure("b2b_a", 2, 510, 1'b0);
        measure("b2b_b", 2, 510, 1'b0);
        v = 1'b0;

        // accept coinciding with a boundary, PRESCALE=1
        do_reset();
        send("bnd_x", 1, 50, 50, 50, 1);
        wait_fs("bnd", 1, 600, n);
        repeat (254) cyc();
        {dr, dg, db} = {8'd100, 8'd100, 8'd100};
        v = 1'b1;
        chk("bnd_ready_on_boundary", int'(rdy[1]), 1);
        exp_q.push_back(100); exp_q.push_back(100); exp_q.push_back(100);
        cyc();
        v = 1'b0;
        chk("bnd_ready_after", int'(rdy[1]), 0);
        measure("bnd_old", 1, 255, 1'b0);
        measure("bnd_new", 1, 255, 1'b0);

        // reset mid-operation with duty 255 active and a pending value
        do_reset();
        send("mid", 1, 255, 255, 255, 1);
        wait_fs("mid", 1, 600, n);
        repeat (100) cyc();
        chk("mid_pins_on", pins(1), 7);
        {dr, dg, db} = {8'd77, 8'd77, 8'd77};
        v = 1'b1;
        cyc();
        chk("mid_pending_held", int'(rdy[1]), 0);
        reset = 1'b1;
        v = 1'b0;
        exp_q.delete();
        cyc();
        chk("mid_pins_off", pins(1), 0);
        chk("mid_ready_rst", int'(rdy[1]), 1);
        cyc();
        cyc();
        reset = 1'b0;
        begin
            int on = 0, fc = 0;
            for (int i = 0; i < 600; i++) begin
                on += int'(rl[1] | gl[1] | bl[1]);
                fc += int'(fs[1]);
                cyc();
            end
            chk("mid_no_pulse", on, 0);
            chk("mid_fs_count", fc, 2);
        end

        // inverted pins, PRESCALE=1, ACTIVE_LOW=1
        reset = 1'b1;
        cyc();
        chk("inv_rst_pins", pins(3), 7);
        cyc();
        cyc();
        reset = 1'b0;
        chk("inv_c0_pins", pins(3), 7);
        send("inv", 3, 64, 64, 64, 1);
        wait_fs("inv", 3, 600, n);
        measure("inv_p1", 3, 255, 1'b1);
        exp_q.push_back(64); exp_q.push_back(64); exp_q.push_back(64);
        measure("inv_p2", 3, 255, 1'b1);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
